// File: rtl/bch_542_512_pkg.sv
// Shared BCH(542,512) constants (t=3 over GF(2^10)), used by the encoder and the decoder chain.
package bch_542_512_pkg;

    localparam int BCH_N        = 542;
    localparam int BCH_K        = 512;
    localparam int BCH_PARITY_W = 30;
    localparam int BCH_M        = 10;

    // g(x) = m1*m3*m5 for primitive x^10+x^3+1; bit i is the x^i coefficient.
    localparam logic [BCH_PARITY_W:0]   BCH_GEN_POLY = 31'h50A9_1113;
    localparam logic [BCH_PARITY_W-1:0] BCH_G_LOW    = BCH_GEN_POLY[BCH_PARITY_W-1:0];

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } enc_state_e;

endpackage

// File: rtl/bch_enc_lfsr_step.sv
// One beat of the systematic BCH remainder LFSR: DATA_W serial shifts unrolled, MSB of the beat first.
module bch_enc_lfsr_step
    import bch_542_512_pkg::*;
#(
    parameter int                   DATA_W   = 32,
    parameter int                   PARITY_W = BCH_PARITY_W,
    parameter logic [PARITY_W-1:0]  G_LOW    = BCH_G_LOW
) (
    input  logic [PARITY_W-1:0] lfsr_in,
    input  logic [DATA_W-1:0]   data_in,
    output logic [PARITY_W-1:0] lfsr_out
);

    logic [PARITY_W-1:0] acc;
    logic                fb;

    always_comb begin
        acc = lfsr_in;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = acc[PARITY_W-1] ^ data_in[i];
            acc = {acc[PARITY_W-2:0], 1'b0} ^ (fb ? G_LOW : '0);
        end
        lfsr_out = acc;
    end

endmodule

// File: rtl/bch_encoder_542_512.sv
// Systematic BCH(542,512) encoder: passes K message bits through in DATA_W beats, then appends one parity beat.
// Handshake: a beat moves when valid && ready on a rising edge; the producer holds valid and data stable until then.
module bch_encoder_542_512
    import bch_542_512_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int K        = BCH_K,
    parameter int PARITY_W = BCH_PARITY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              len_err
);

    localparam int               BEATS     = K / DATA_W;
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    enc_state_e          state_q;
    logic                run_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                len_err_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [PARITY_W-1:0] lfsr_q;
    logic [PARITY_W-1:0] lfsr_d;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic                out_free;
    logic                accept;

    // run_q keeps in_ready low until the first clock after reset release.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = run_q && (state_q == ST_DATA) && out_free;
    assign accept   = in_valid && in_ready;

    bch_enc_lfsr_step #(
        .DATA_W   (DATA_W),
        .PARITY_W (PARITY_W),
        .G_LOW    (PARITY_W'(BCH_G_LOW))
    ) u_step (
        .lfsr_in  (lfsr_q),
        .data_in  (in_data),
        .lfsr_out (lfsr_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DATA;
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            len_err_q   <= 1'b0;
            lfsr_q      <= '0;
            beat_cnt_q  <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                ST_DATA: begin
                    if (accept) begin
                        out_data_q  <= in_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        lfsr_q      <= lfsr_d;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= ST_PARITY;
                            if (!in_last) len_err_q <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                            if (in_last) len_err_q <= 1'b1;
                        end
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    // out_free is the only gate here: a stalled data beat simply holds.
                    if (out_free) begin
                        out_data_q  <= DATA_W'(lfsr_q);
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                        lfsr_q      <= '0;
                        state_q     <= ST_DATA;
                    end
                end
                default: state_q <= ST_DATA;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_bch_encoder_542_512.sv
// Directed bench for bch_encoder_542_512: polynomial-division and GF(2^10) syndrome model, scoreboard queue.
module tb_bch_encoder_542_512;

    localparam int DATA_W = 32;
    localparam int K      = 512;
    localparam int PW     = 30;
    localparam int N      = 542;
    localparam int BEATS  = K / DATA_W;
    localparam int LIMIT  = 2000;
    // x^30+x^28+x^23+x^21+x^19+x^16+x^12+x^8+x^4+x+1, derived by hand from m1*m3*m5.
    localparam logic [PW:0] GEN_TB = 31'h50A9_1113;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              len_err;

    int n_checks = 0;
    int n_err    = 0;

    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W:0]   got_q[$];
    logic [K-1:0]      msg_a [2];
    int                last_at [2];
    int                first_acc, last_cyc, rdy_low;
    logic [DATA_W-1:0] last_par, par_ns;
    logic [N-1:0]      last_cw, flip_cw;
    int                p1, p2;

    bch_encoder_542_512 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic logic [PW-1:0] poly_mod(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = v;
        for (int i = N - 1; i >= PW; i--)
            if (r[i]) r[i -: PW+1] = r[i -: PW+1] ^ GEN_TB;
        return r[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] parity_of(input logic [K-1:0] m);
        return poly_mod({m, {PW{1'b0}}});
    endfunction

    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] x;
        logic [9:0]  p;
        x = {1'b0, a};
        p = '0;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) p = p ^ x[9:0];
            x = x << 1;
            if (x[10]) x = x ^ 11'h409;
        end
        return p;
    endfunction

    function automatic logic [9:0] alpha_pow(input int e);
        logic [9:0] r;
        r = 10'h001;
        for (int i = 0; i < e % 1023; i++) r = gf_mul(r, 10'h002);
        return r;
    endfunction

    function automatic logic [9:0] syndrome(input logic [N-1:0] c, input int j);
        logic [9:0] aj, s;
        aj = alpha_pow(j);
        s  = '0;
        for (int i = N - 1; i >= 0; i--) s = gf_mul(s, aj) ^ {9'b0, c[i]};
        return s;
    endfunction

    task automatic rand_msg(output logic [K-1:0] m);
        for (int w = 0; w < BEATS; w++) m[K-1-DATA_W*w -: DATA_W] = $urandom();
    endtask

    // Drives n_cw messages from msg_a; out_ready is low with probability stall_pct percent.
    task automatic run_stream(input int n_cw, input int stall_pct, input string tag);
        int                beat, cw, got, cyc;
        logic              prev_stall, prev_last;
        logic [DATA_W-1:0] prev_data;
        beat = 0; cw = 0; got = 0; cyc = 0;
        first_acc = -1; last_cyc = -1; rdy_low = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        got_q.delete();
        while (got < n_cw * (BEATS + 1) && cyc < LIMIT) begin
            @(negedge clk);
            if (cw < n_cw) begin
                in_valid = 1'b1;
                in_data  = msg_a[cw][K-1-DATA_W*beat -: DATA_W];
                in_last  = (beat == last_at[cw]);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
                in_last  = 1'b0;
            end
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            #1;
            if (prev_stall) begin
                check({tag, " hold data"}, out_data, prev_data);
                check({tag, " hold last"}, out_last, prev_last);
            end
            if (out_valid && !out_ready) check({tag, " stall in_ready"}, in_ready, 1'b0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (first_acc >= 0 && !in_ready) rdy_low++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                got++;
                if (out_last) last_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                if (beat == BEATS - 1) begin
                    beat = 0;
                    cw++;
                end else begin
                    beat++;
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, " completes in budget"}, cyc < LIMIT, 1'b1);
    endtask

    task automatic score(input int n_cw, input string tag);
        logic [DATA_W:0] e, g;
        logic [K-1:0]    rx;
        int              n;
        exp_q.delete();
        for (int c = 0; c < n_cw; c++) begin
            for (int b = 0; b < BEATS; b++) exp_q.push_back({1'b0, msg_a[c][K-1-DATA_W*b -: DATA_W]});
            exp_q.push_back({1'b1, DATA_W'(parity_of(msg_a[c]))});
        end
        check({tag, " beat count"}, got_q.size(), exp_q.size());
        n  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        rx = '0;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " beat"}, g, e);
            if (g[DATA_W]) begin
                last_par = g[DATA_W-1:0];
                last_cw  = {rx, g[PW-1:0]};
                check({tag, " codeword mod g"}, poly_mod(last_cw), '0);
                check({tag, " S1"}, syndrome(last_cw, 1), '0);
                check({tag, " S3"}, syndrome(last_cw, 3), '0);
                check({tag, " S5"}, syndrome(last_cw, 5), '0);
            end else begin
                rx = {rx[K-DATA_W-1:0], g[DATA_W-1:0]};
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        last_at[0] = BEATS - 1;
        last_at[1] = BEATS - 1;

        // Reset values, and in_ready held low until the first clock after release.
        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, '0);
        check("reset out_last", out_last, 1'b0);
        check("reset len_err", len_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready before first clk", in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("in_ready after first clk", in_ready, 1'b1);

        // All-zero message: 16 zero beats, zero parity, 17-cycle cadence.
        msg_a[0] = '0;
        run_stream(1, 0, "zero");
        check("zero cadence", last_cyc - first_acc, 17);
        check("zero ready drops", rdy_low, 1);
        score(1, "zero");
        check("zero parity", last_par, 32'h0);
        check("zero len_err", len_err, 1'b0);

        // m(x)=1 gives x^30 mod g = G_LOW; m(x)=x gives G_LOW<<1 (no x^30 term to reduce).
        msg_a[0] = 512'd1;
        run_stream(1, 0, "msg1");
        score(1, "msg1");
        check("msg1 parity", last_par, 32'h10A9_1113);
        msg_a[0] = 512'd2;
        run_stream(1, 0, "msg2");
        score(1, "msg2");
        check("msg2 parity", last_par, 32'h2152_2226);

        // Random message, first without stalls, then with back-pressure.
        rand_msg(msg_a[0]);
        run_stream(1, 0, "rand");
        score(1, "rand");
        par_ns = last_par;
        run_stream(1, 40, "stall");
        score(1, "stall");
        check("stall parity equals no-stall", last_par, par_ns);
        check("stall len_err", len_err, 1'b0);

        // Error patterns on the last codeword give the expected syndromes.
        p1 = $urandom_range(0, N - 1);
        p2 = (p1 + $urandom_range(1, N - 1)) % N;
        flip_cw = last_cw;
        flip_cw[p1] = ~flip_cw[p1];
        check("1 flip S1", syndrome(flip_cw, 1), alpha_pow(p1));
        check("1 flip S3", syndrome(flip_cw, 3), alpha_pow(3 * p1));
        flip_cw[p2] = ~flip_cw[p2];
        check("2 flip S1", syndrome(flip_cw, 1), alpha_pow(p1) ^ alpha_pow(p2));

        // Back-to-back codewords: independent parities, in_ready low only on the two parity cycles.
        rand_msg(msg_a[0]);
        rand_msg(msg_a[1]);
        run_stream(2, 0, "b2b");
        check("b2b cadence", last_cyc - first_acc, 34);
        check("b2b ready drops", rdy_low, 2);
        score(2, "b2b");

        // Early in_last: flagged, but the full message is still consumed.
        rand_msg(msg_a[0]);
        last_at[0] = 10;
        run_stream(1, 0, "early last");
        score(1, "early last");
        check("early last len_err", len_err, 1'b1);

        // Asynchronous reset in the middle of a message.
        last_at[0] = BEATS - 1;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = msg_a[0][K-1-DATA_W*b -: DATA_W];
            in_last   = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", out_valid, 1'b0);
        check("mid reset out_data", out_data, '0);
        check("mid reset out_last", out_last, 1'b0);
        check("mid reset len_err", len_err, 1'b0);
        check("mid reset in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_msg(msg_a[0]);
        run_stream(1, 0, "after reset");
        score(1, "after reset");
        check("after reset len_err", len_err, 1'b0);

        // Missing in_last on the final beat.
        last_at[0] = -1;
        run_stream(1, 0, "no last");
        score(1, "no last");
        check("no last len_err", len_err, 1'b1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
